// File: rtl/job_fetcher.sv
// job_fetcher: reads 64-byte descriptor lines from a host ring over AXI4 and dispatches jobs to idle kernels.
//
// Optional feature: define JOB_FETCH_CNT_EN to add dispatch_cnt_o, a wrapping count of kernel_start pulses.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             one-cycle pulse that begins a fetch run (ignored unless idle)
//   queue_addr_i        ring base byte address, 64-byte aligned
//   queue_size_i        ring size in bytes, multiple of 64 (zero is reported as an error)
//   kernel_idle_i       per-kernel idle level
//   kernel_start_o      registered one-hot start pulse
//   job_id_o            ID of the last dispatched job, valid together with kernel_start_o
//   fetch_done_o        one-cycle pulse when the run ends
//   fetch_error_o       sticky error (zero-size ring or error response), cleared by start_i
//   dispatch_cnt_o      dispatch counter (JOB_FETCH_CNT_EN only)
//   m_axi_ar*, m_axi_r* AXI4 read master issuing single-beat 64-byte reads
module job_fetcher #(
    parameter int KERNEL_NUM   = 8,
    parameter int ID_WIDTH     = 1,
    parameter int ARUSER_WIDTH = 8,
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   queue_addr_i,
    input  logic [31:0]             queue_size_i,
    input  logic [KERNEL_NUM-1:0]   kernel_idle_i,
    output logic [KERNEL_NUM-1:0]   kernel_start_o,
    output logic [23:0]             job_id_o,
    output logic                    fetch_done_o,
    output logic                    fetch_error_o,
`ifdef JOB_FETCH_CNT_EN
    output logic [31:0]             dispatch_cnt_o,
`endif
    output logic [ID_WIDTH-1:0]     m_axi_arid_o,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr_o,
    output logic [7:0]              m_axi_arlen_o,
    output logic [2:0]              m_axi_arsize_o,
    output logic [1:0]              m_axi_arburst_o,
    output logic [3:0]              m_axi_arcache_o,
    output logic                    m_axi_arlock_o,
    output logic [2:0]              m_axi_arprot_o,
    output logic [3:0]              m_axi_arqos_o,
    output logic [3:0]              m_axi_arregion_o,
    output logic [ARUSER_WIDTH-1:0] m_axi_aruser_o,
    output logic                    m_axi_arvalid_o,
    input  logic                    m_axi_arready_i,
    input  logic [ID_WIDTH-1:0]     m_axi_rid_i,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata_i,
    input  logic [1:0]              m_axi_rresp_i,
    input  logic                    m_axi_rlast_i,
    input  logic                    m_axi_rvalid_i,
    output logic                    m_axi_rready_o
);
    typedef enum logic [2:0] {IDLE, REQ, DATA, DISPATCH, DONE} state_t;

    state_t                state_q, state_d;
    logic [31:0]           offset_q, offset_d, next_offset;
    logic [3:0]            idx_q, idx_d;
    logic [KERNEL_NUM-1:0] pending_q, pending_d, elig, sel;
    logic [KERNEL_NUM-1:0] kernel_start_q, kernel_start_d;
    logic [15:0][31:0]     buf_q, buf_d;
    logic [31:0]           word;
    logic [23:0]           job_id_q, job_id_d;
    logic                  fetch_done_q, fetch_done_d;
    logic                  fetch_error_q, fetch_error_d;
    logic                  unused_r;

    assign m_axi_arid_o     = '0;
    assign m_axi_arlen_o    = 8'd0;
    assign m_axi_arsize_o   = 3'b110;
    assign m_axi_arburst_o  = 2'b01;
    assign m_axi_arcache_o  = 4'b0011;
    assign m_axi_arlock_o   = 1'b0;
    assign m_axi_arprot_o   = 3'b000;
    assign m_axi_arqos_o    = 4'b0000;
    assign m_axi_arregion_o = 4'b0000;
    assign m_axi_aruser_o   = '0;
    assign m_axi_arvalid_o  = state_q == REQ;
    assign m_axi_araddr_o   = queue_addr_i + ADDR_WIDTH'(offset_q);
    assign m_axi_rready_o   = state_q == DATA;
    assign unused_r         = ^{m_axi_rid_i, m_axi_rlast_i};

    assign kernel_start_o = kernel_start_q;
    assign job_id_o       = job_id_q;
    assign fetch_done_o   = fetch_done_q;
    assign fetch_error_o  = fetch_error_q;

    assign word        = buf_q[idx_q];
    assign elig        = kernel_idle_i & ~pending_q;
    // Two's-complement trick isolates the lowest set bit: lowest index wins.
    assign sel         = elig & (-elig);
    assign next_offset = offset_q + 32'd64;

    always_comb begin
        state_d        = state_q;
        offset_d       = offset_q;
        idx_d          = idx_q;
        // A kernel that has dropped idle has taken its job, so its pending guard can go.
        pending_d      = pending_q & kernel_idle_i;
        buf_d          = buf_q;
        kernel_start_d = '0;
        job_id_d       = job_id_q;
        fetch_error_d  = fetch_error_q;
        case (state_q)
            IDLE: if (start_i) begin
                offset_d      = '0;
                idx_d         = '0;
                pending_d     = '0;
                fetch_error_d = queue_size_i == 32'd0;
                state_d       = fetch_error_d ? DONE : REQ;
            end
            REQ: state_d = m_axi_arready_i ? DATA : REQ;
            DATA: if (m_axi_rvalid_i) begin
                if (m_axi_rresp_i != 2'b00) begin
                    fetch_error_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    buf_d   = m_axi_rdata_i;
                    idx_d   = '0;
                    state_d = DISPATCH;
                end
            end
            DISPATCH: if (word[7:0] != 8'h01) begin
                state_d = DONE;
            end else if (|elig) begin
                kernel_start_d = sel;
                job_id_d       = word[31:8];
                // Setting the bit after the idle-based clear makes a same-cycle idle fall lose to the new dispatch.
                pending_d      = pending_d | sel;
                if (idx_q == 4'd15) begin
                    offset_d = next_offset == queue_size_i ? 32'd0 : next_offset;
                    state_d  = REQ;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        fetch_done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            offset_q       <= '0;
            idx_q          <= '0;
            pending_q      <= '0;
            buf_q          <= '0;
            kernel_start_q <= '0;
            job_id_q       <= '0;
            fetch_done_q   <= 1'b0;
            fetch_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            offset_q       <= offset_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            buf_q          <= buf_d;
            kernel_start_q <= kernel_start_d;
            job_id_q       <= job_id_d;
            fetch_done_q   <= fetch_done_d;
            fetch_error_q  <= fetch_error_d;
        end
    end

`ifdef JOB_FETCH_CNT_EN
    logic [31:0] dispatch_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dispatch_cnt_q <= '0;
        else if (state_q == IDLE && start_i) dispatch_cnt_q <= '0;
        else if (|kernel_start_d) dispatch_cnt_q <= dispatch_cnt_q + 32'd1;
    end

    assign dispatch_cnt_o = dispatch_cnt_q;
`endif
endmodule
